ccff_chain_loader: RTL



---
 rtl/ccff_chain_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain bitstream writer: serialises host words MSB-first into ccff_head
// and captures the outgoing chain image from ccff_tail as left-justified readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 32
) (
  input  logic                           prog_clk,
  input  logic                           prog_reset,
  input  logic                           start,
  input  logic                           word_valid,
  input  logic [WORD_W-1:0]              word_data,
  output logic                           word_ready,
  output logic                           ccff_head,
  input  logic                           ccff_tail,
  output logic                           chain_clk_en,
  output logic                           rb_valid,
  output logic [WORD_W-1:0]              rb_data,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int BC_W  = $clog2(CHAIN_LEN+1);
  localparam int CNT_W = $clog2(WORD_W+1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] rb_acc;
  logic [CNT_W-1:0]  rb_cnt;
  logic [31:0]       remaining;
  logic              handshake;
  logic              last_shift;
  logic [WORD_W-1:0] rb_next;
  logic [CNT_W-1:0]  rb_cnt_next;
  logic [CNT_W-1:0]  load_cnt;

  // Bits still owed to the chain beyond what is already buffered in shreg.
  assign remaining    = 32'(CHAIN_LEN) - 32'(bit_count) - 32'(cnt);
  assign busy         = (state == LOAD);
  assign done         = (state == DONE);
  assign chain_clk_en = busy && (cnt != '0);
  assign ccff_head    = (cnt != '0) && shreg[WORD_W-1];
  assign word_ready   = busy && (cnt <= CNT_W'(1)) && (remaining != 32'd0);
  assign handshake    = word_ready && word_valid;
  assign last_shift   = chain_clk_en && (32'(bit_count) == 32'(CHAIN_LEN - 1));
  assign load_cnt     = (remaining >= 32'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(remaining);
  assign rb_next      = {rb_acc[WORD_W-2:0], ccff_tail};
  assign rb_cnt_next  = rb_cnt + CNT_W'(1);

  // A reload at cnt==1 replaces the shift so back-to-back words stream with no bubble.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_count <= '0;
      rb_acc    <= '0;
      rb_cnt    <= '0;
      rb_valid  <= 1'b0;
      rb_data   <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            shreg     <= '0;
            cnt       <= '0;
            bit_count <= '0;
            rb_acc    <= '0;
            rb_cnt    <= '0;
          end
        end
        LOAD: begin
          if (handshake) begin
            shreg <= word_data;
            cnt   <= load_cnt;
          end else if (chain_clk_en) begin
            shreg <= shreg << 1;
            cnt   <= cnt - CNT_W'(1);
          end
          if (chain_clk_en) begin
            bit_count <= bit_count + BC_W'(1);
            if (rb_cnt_next == CNT_W'(WORD_W)) begin
              rb_data  <= rb_next;
              rb_valid <= 1'b1;
              rb_acc   <= '0;
              rb_cnt   <= '0;
            end else begin
              rb_acc <= rb_next;
              rb_cnt <= rb_cnt_next;
              // Leftover samples are flushed left-justified with zero fill.
              if (last_shift) begin
                rb_data  <= rb_next << (CNT_W'(WORD_W) - rb_cnt_next);
                rb_valid <= 1'b1;
              end
            end
            if (last_shift) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
